dual_port_ram: RTL and testbench
================================

# dual_port_ram

Simple dual-port synchronous RAM: one write port and one independent read port, both on a single clock. Used as generic storage, such as the register file or small buffers, inside the core. Writes are committed on the rising clock edge. Reads are registered, with one-cycle latency.

## Interface
Parameters:
- XLEN, default 32: word width in bits.
- ADDR_WIDTH, default 5: address width. Depth is 2**ADDR_WIDTH words (32 at default).

Ports:
- i_clk  input  1: single clock; all state changes on its rising edge.
- i_rst_n  input  1: synchronous, active-low reset.
- i_we  input  1: write enable.
- i_wAddr  input  ADDR_WIDTH: write address.
- i_dataIn  input  XLEN: write data.
- i_rAddr  input  ADDR_WIDTH: read address.
- o_q  output  XLEN: registered read data.

## Operation
- Storage: array of 2**ADDR_WIDTH words, each XLEN bits wide.
- Write: at a rising edge with i_rst_n=1 and i_we=1, mem[i_wAddr] <= i_dataIn. With i_we=0, no array location changes.
- Read: at every rising edge with i_rst_n=1, o_q <= mem[i_rAddr]. The read port has no enable.
- Reset: at a rising edge with i_rst_n=0:
  - o_q <= 0.
  - Writes are suppressed.
  - Array contents are preserved, not cleared.
- Power-up array contents are undefined (X in simulation). The bench must write a location before reading it.
- Read and write to the same address on the same edge: read-first. o_q receives the old contents and the new data is readable from the next edge.
- Write and read addresses are fully independent and cover the full range 0..2**ADDR_WIDTH-1, with no wrap or bounds logic.
- The coding style must infer block RAM. Reset may touch only the output register.

## Timing
- Write latency: data written at edge N is returned by a read sampled at edge N+1 or later.
- Read latency: one cycle. i_rAddr sampled at edge N appears on o_q after edge N and is held until the next edge.
- o_q reset value is 0 and stays 0 on every edge while i_rst_n=0.
- On the first edge after reset deasserts, o_q <= mem[i_rAddr].
- Reset asserted mid-operation: at that edge any pending write is dropped, o_q clears, and the array is otherwise intact.
- There is no handshake; the port accepts one write and one read every cycle.
- All inputs must be stable around the rising edge. Benches drive inputs away from the edge, e.g. on the falling edge.

## Structure
- Single flat module; no sub-module.
- No shared package is needed. XLEN and ADDR_WIDTH come from the parent, which uses the core-wide XLEN constant from the project package.
- Depth is a localparam derived from ADDR_WIDTH.

## Test plan
- Fill and readback: with i_we=1, write addresses 0..9 with 0xdeadbeef, 0x8badf00d, 0x00c0ffee, 0xdeadc0de, 0xbadf000d, 0xdefac8ed, 0xcafebabe, 0xdeadd00d, 0xcafed00d, 0xdeadbabe. Then set i_we=0 and read 0..9 -> each o_q matches its word one cycle after its address is sampled, 0 errors.
- Reset: hold i_rst_n=0 for 2 cycles -> o_q=0. Then deassert with i_rAddr=3 -> o_q=0xdeadc0de, proving contents survived.
- Write-enable gating: with i_we=0, drive i_wAddr=5 and i_dataIn=0x12345678 -> a read of address 5 still returns 0xdefac8ed.
- Same-address collision: write 0xa5a5a5a5 to address 2 while reading address 2 -> o_q=0x00c0ffee on that edge and 0xa5a5a5a5 on the next edge.
- Address extremes: write 0x11111111 to 0 and 0xffffffff to 31 -> reads return those values with no aliasing.
- Write during reset: i_rst_n=0, i_we=1, write 0xbeefbeef to address 7 -> after reset, address 7 still reads 0xdeadd00d.

Source files
------------

// File: rtl/dual_port_ram_pkg.sv
// Default geometry for the simple dual-port RAM; parents normally override
// these with the core-wide word width.
package dual_port_ram_pkg;

  localparam int unsigned DEFAULT_XLEN       = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

endpackage : dual_port_ram_pkg

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// single clock. Read-first on same-address collisions.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int unsigned XLEN       = DEFAULT_XLEN,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_wAddr,
  input  logic [XLEN-1:0]       i_dataIn,
  input  logic [ADDR_WIDTH-1:0] i_rAddr,
  output logic [XLEN-1:0]       o_q
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [XLEN-1:0] mem_q [DEPTH];

  // Storage has no reset so it maps onto block RAM; writes are held off in reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_we) begin
      mem_q[i_wAddr] <= i_dataIn;
    end
  end

  // Output register is the only resettable state; samples old contents on collision.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else begin
      o_q <= mem_q[i_rAddr];
    end
  end

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: fill/readback, reset retention, write
// gating, read-first collision, address extremes, writes during reset.
module tb_dual_port_ram;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  logic                  clk;
  logic                  rst_n;
  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [XLEN-1:0]       data_in;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [XLEN-1:0]       q;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [XLEN-1:0] fill_words [10];

  dual_port_ram #(
    .XLEN       (XLEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_we     (we),
    .i_wAddr  (w_addr),
    .i_dataIn (data_in),
    .i_rAddr  (r_addr),
    .o_q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_q(input string tag, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; one rising edge is consumed, then
  // outputs are sampled on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    fill_words[0] = 32'hdeadbeef;
    fill_words[1] = 32'h8badf00d;
    fill_words[2] = 32'h00c0ffee;
    fill_words[3] = 32'hdeadc0de;
    fill_words[4] = 32'hbadf000d;
    fill_words[5] = 32'hdefac8ed;
    fill_words[6] = 32'hcafebabe;
    fill_words[7] = 32'hdeadd00d;
    fill_words[8] = 32'hcafed00d;
    fill_words[9] = 32'hdeadbabe;

    rst_n   = 1'b0;
    we      = 1'b0;
    w_addr  = '0;
    data_in = '0;
    r_addr  = '0;
    @(negedge clk);
    step();
    step();
    check_q("reset_q", q, 32'h0);

    // Fill addresses 0..9
    rst_n = 1'b1;
    we    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w_addr  = ADDR_WIDTH'(i);
      data_in = fill_words[i];
      step();
    end

    // Readback 0..9
    we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      r_addr = ADDR_WIDTH'(i);
      step();
      check_q($sformatf("fill_rd%0d", i), q, fill_words[i]);
    end

    // Reset holds q at zero and preserves contents
    rst_n = 1'b0;
    step();
    check_q("rst_hold1", q, 32'h0);
    step();
    check_q("rst_hold2", q, 32'h0);
    rst_n  = 1'b1;
    r_addr = ADDR_WIDTH'(3);
    step();
    check_q("rst_retain3", q, 32'hdeadc0de);

    // Write enable low must not modify the array
    we      = 1'b0;
    w_addr  = ADDR_WIDTH'(5);
    data_in = 32'h12345678;
    step();
    r_addr = ADDR_WIDTH'(5);
    step();
    check_q("we_gate5", q, 32'hdefac8ed);

    // Same-address collision is read-first
    we      = 1'b1;
    w_addr  = ADDR_WIDTH'(2);
    data_in = 32'ha5a5a5a5;
    r_addr  = ADDR_WIDTH'(2);
    step();
    check_q("coll_old", q, 32'h00c0ffee);
    we = 1'b0;
    step();
    check_q("coll_new", q, 32'ha5a5a5a5);

    // Address extremes
    we      = 1'b1;
    w_addr  = ADDR_WIDTH'(0);
    data_in = 32'h11111111;
    step();
    w_addr  = ADDR_WIDTH'(31);
    data_in = 32'hffffffff;
    step();
    we     = 1'b0;
    r_addr = ADDR_WIDTH'(0);
    step();
    check_q("ext_rd0", q, 32'h11111111);
    r_addr = ADDR_WIDTH'(31);
    step();
    check_q("ext_rd31", q, 32'hffffffff);
    r_addr = ADDR_WIDTH'(1);
    step();
    check_q("ext_rd1", q, 32'h8badf00d);
    r_addr = ADDR_WIDTH'(9);
    step();
    check_q("ext_rd9", q, 32'hdeadbabe);

    // Writes are dropped while in reset
    rst_n   = 1'b0;
    we      = 1'b1;
    w_addr  = ADDR_WIDTH'(7);
    data_in = 32'hbeefbeef;
    r_addr  = ADDR_WIDTH'(7);
    step();
    check_q("rstwr_q", q, 32'h0);
    rst_n = 1'b1;
    we    = 1'b0;
    step();
    check_q("rstwr_rd7", q, 32'hdeadd00d);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dual_port_ram
